branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, direct-mapped table depth (power of 2, 2..256).
REQ-002 SHALL have parameter CNT_W, default 2, saturating-counter width (1..4).
REQ-003 SHALL have port CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port lk_pc  in  32  fetch-stage PC to look up.
REQ-006 SHALL have port lk_stall  in  1  fetch stalled; lookup not counted.
REQ-007 SHALL have port lk_hit  out  1  valid tag match for lk_pc.
REQ-008 SHALL have port lk_taken  out  1  predict taken (hit and counter MSB=1).
REQ-009 SHALL have port lk_target  out  32  predicted next PC (target if lk_taken, else lk_pc+4).
REQ-010 SHALL have port up_valid  in  1  resolved control-flow instruction present this cycle.
REQ-011 SHALL have port up_pc, up_target  in  32 each  resolved PC and computed branch target.
REQ-012 SHALL have port up_taken  in  1  actual outcome.
REQ-013 SHALL have port up_pred_taken, up_pred_target  in  1/32  prediction carried down the pipeline.
REQ-014 SHALL have port up_result  out  pred_t  RIGHT_PRED / WRONG_PRED / NA.
REQ-015 SHALL have port up_fix_pc  out  32  correct PC (up_target if up_taken, else up_pc+4).
REQ-016 SHALL have port n_lookups, n_mispred  out  32 each  statistics counters.

Function
REQ-017 Index SHALL be pc[IDX_W+1:2], tag pc[31:IDX_W+2], IDX_W=log2(ENTRIES); entry = valid, tag, target, CNT_W counter.
REQ-018 Lookup SHALL be combinational (zero latency) from lk_pc and current table state.
REQ-019 up_result SHALL be NA when up_valid=0; RIGHT_PRED when up_pred_taken==up_taken and (up_taken=0 or up_pred_target==up_target); else WRONG_PRED; combinational.
REQ-020 On up_valid with tag hit: counter +1 if taken (saturate at 2^CNT_W-1), -1 if not (saturate at 0); target overwritten with up_target if taken.
REQ-021 On up_valid, miss, up_taken=1: entry allocated (overwrite any occupant), valid=1, tag/target written, counter=2^(CNT_W-1) (weakly taken).
REQ-022 On up_valid, miss, up_taken=0: no table change.
REQ-023 Same-cycle lookup and update to one index: lookup SHALL return pre-update contents; update visible next cycle.
REQ-024 n_lookups SHALL increment each cycle lk_stall=0; n_mispred each cycle up_result==WRONG_PRED; both wrap 2^32-1 -> 0.
REQ-025 lk_pc with nonzero bits [1:0] SHALL be indexed ignoring those bits.

Reset
REQ-026 RST=1 SHALL immediately clear all valid bits, counters, targets, and n_lookups/n_mispred to 0, regardless of clock.
REQ-027 During and after reset until first allocation: lk_hit=0, lk_taken=0, lk_target=lk_pc+4.
REQ-028 Update asserted in the cycle reset deasserts SHALL be applied at the next rising edge.

Structure
REQ-029 pred_t, word_t and a new btb_entry_t typedef SHALL live in datapath_types_pkg; default ENTRIES/CNT_W constants there too.
REQ-030 Saturating counter logic SHALL be a sub-module sat_counter (param CNT_W, in: cur, inc, en; out: next).

Verification
REQ-031 After reset, lk_pc=0x40 -> lk_hit=0, lk_target=0x44; n_lookups=1 after one unstalled cycle.
REQ-032 Update pc=0x40 taken target=0x100 (miss) -> next cycle lk_pc=0x40 gives hit=1, taken=1, target=0x100, counter=2; up_result=WRONG_PRED, up_fix_pc=0x100, n_mispred=1.
REQ-033 Three not-taken updates at 0x40 from counter 2 -> counter 1, 0, 0 (saturated); lk_taken=0, lk_target=0x44; four taken updates -> 1,2,3,3.
REQ-034 Alias: ENTRIES=16, allocate 0x40 then taken update 0x80 (same index, different tag) -> 0x40 misses, 0x80 hits.
REQ-035 Same-cycle update and lookup at 0x40 -> lookup shows old entry; following cycle shows new.
REQ-036 Assert RST between clock edges with table populated -> all outputs and counters 0 immediately; lookups miss after release.

Source files
------------

// File: rtl/datapath_types_pkg.sv
// Shared datapath types for the branch predictor: word, prediction verdict, table entry.
// Also holds the default table geometry.
package datapath_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        NA         = 2'd0,
        RIGHT_PRED = 2'd1,
        WRONG_PRED = 2'd2
    } pred_t;

    localparam int DEF_ENTRIES = 16;
    localparam int DEF_CNT_W   = 2;

    // The tag is kept as the full shifted PC so one entry type serves every ENTRIES value.
    // The saturating counter is held in a separate array because its width is a module parameter.
    typedef struct packed {
        logic  valid;
        word_t tag;
        word_t target;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup and update buses of the branch predictor.
// The fetch/execute side uses the master modport; the predictor uses the slave modport.
interface branch_predictor_if;
    import datapath_types_pkg::*;

    word_t lk_pc;
    logic  lk_stall;
    logic  lk_hit;
    logic  lk_taken;
    word_t lk_target;

    logic  up_valid;
    word_t up_pc;
    word_t up_target;
    logic  up_taken;
    logic  up_pred_taken;
    word_t up_pred_target;
    pred_t up_result;
    word_t up_fix_pc;

    word_t n_lookups;
    word_t n_mispred;

    modport master (
        output lk_pc, lk_stall, up_valid, up_pc, up_target, up_taken,
               up_pred_taken, up_pred_target,
        input  lk_hit, lk_taken, lk_target, up_result, up_fix_pc,
               n_lookups, n_mispred
    );

    modport slave (
        input  lk_pc, lk_stall, up_valid, up_pc, up_target, up_taken,
               up_pred_taken, up_pred_target,
        output lk_hit, lk_taken, lk_target, up_result, up_fix_pc,
               n_lookups, n_mispred
    );

endinterface

// File: rtl/sat_counter.sv
// Next value of a CNT_W-bit saturating up/down counter.
// When en is low the value passes through unchanged.
module sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cur,
    input  logic             inc,
    input  logic             en,
    output logic [CNT_W-1:0] next
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_comb begin
        next = cur;
        if (en) begin
            if (inc) begin
                if (cur != CNT_MAX) next = cur + CNT_ONE;
            end else begin
                if (cur != '0) next = cur - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational. Updates come from the resolve stage. Also counts lookups and mispredicts.
module branch_predictor
    import datapath_types_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               CLK,
    input  logic               RST,
    branch_predictor_if.slave  bp
);

    localparam int               IDX_W    = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

    btb_entry_t       table_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q   [ENTRIES];
    word_t            n_lookups_q;
    word_t            n_mispred_q;

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    word_t            lk_tag;
    word_t            up_tag;
    logic             lk_hit;
    logic             lk_taken;
    logic             up_hit;
    logic [CNT_W-1:0] cnt_d;
    pred_t            result;

    // PC bits [1:0] never reach index or tag, so unaligned fetch PCs alias to their word.
    assign lk_idx = bp.lk_pc[IDX_W+1:2];
    assign up_idx = bp.up_pc[IDX_W+1:2];
    assign lk_tag = bp.lk_pc >> (IDX_W + 2);
    assign up_tag = bp.up_pc >> (IDX_W + 2);

    sat_counter #(.CNT_W(CNT_W)) u_sat_counter (
        .cur  (cnt_q[up_idx]),
        .inc  (bp.up_taken),
        .en   (bp.up_valid && up_hit),
        .next (cnt_d)
    );

    always_comb begin
        lk_hit   = table_q[lk_idx].valid && (table_q[lk_idx].tag == lk_tag);
        up_hit   = table_q[up_idx].valid && (table_q[up_idx].tag == up_tag);
        lk_taken = lk_hit && cnt_q[lk_idx][CNT_W-1];

        result = WRONG_PRED;
        if (!bp.up_valid) begin
            result = NA;
        end else if ((bp.up_pred_taken == bp.up_taken) &&
                     (!bp.up_taken || (bp.up_pred_target == bp.up_target))) begin
            result = RIGHT_PRED;
        end
    end

    assign bp.lk_hit    = lk_hit;
    assign bp.lk_taken  = lk_taken;
    assign bp.lk_target = lk_taken ? table_q[lk_idx].target : bp.lk_pc + 32'd4;
    assign bp.up_result = result;
    assign bp.up_fix_pc = bp.up_taken ? bp.up_target : bp.up_pc + 32'd4;
    assign bp.n_lookups = n_lookups_q;
    assign bp.n_mispred = n_mispred_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
            n_lookups_q <= '0;
            n_mispred_q <= '0;
        end else begin
            if (!bp.lk_stall)          n_lookups_q <= n_lookups_q + 32'd1;
            if (result == WRONG_PRED)  n_mispred_q <= n_mispred_q + 32'd1;

            if (bp.up_valid) begin
                if (up_hit) begin
                    cnt_q[up_idx] <= cnt_d;
                    if (bp.up_taken) table_q[up_idx].target <= bp.up_target;
                end else if (bp.up_taken) begin
                    // A taken miss evicts whatever shares the index.
                    table_q[up_idx] <= '{valid: 1'b1, tag: up_tag, target: bp.up_target};
                    cnt_q[up_idx]   <= CNT_WEAK;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16, CNT_W=2).
// Expected values are queued as stimulus is applied and compared as the DUT responds.
module tb_branch_predictor;
    import datapath_types_pkg::*;

    typedef struct {
        string tag;
        word_t val;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    word_t nt_exp [3] = '{32'd1, 32'd0, 32'd0};
    word_t tk_exp [4] = '{32'd1, 32'd2, 32'd3, 32'd3};

    branch_predictor_if bp();

    branch_predictor #(.ENTRIES(16), .CNT_W(2)) dut (
        .CLK (clk),
        .RST (rst),
        .bp  (bp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed no finish, expected finish before 50000");
        $fatal(1, "timeout");
    end

    task automatic expect_val(input string tag, input word_t v);
        exp_q.push_back('{tag, v});
    endtask

    task automatic check_val(input word_t obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h expected <queued value>", obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic drive_up(input logic v, input word_t pc, input logic tk, input word_t tgt,
                            input logic ptk, input word_t ptgt);
        bp.up_valid       = v;
        bp.up_pc          = pc;
        bp.up_taken       = tk;
        bp.up_target      = tgt;
        bp.up_pred_taken  = ptk;
        bp.up_pred_target = ptgt;
    endtask

    task automatic look(input string nm, input word_t pc, input logic hit, input logic tk,
                        input word_t tgt);
        bp.lk_pc = pc;
        expect_val({nm, "_hit"}, word_t'(hit));
        expect_val({nm, "_taken"}, word_t'(tk));
        expect_val({nm, "_target"}, tgt);
        #1;
        check_val(word_t'(bp.lk_hit));
        check_val(word_t'(bp.lk_taken));
        check_val(bp.lk_target);
    endtask

    task automatic upchk(input string nm, input pred_t res, input word_t fix);
        expect_val({nm, "_result"}, word_t'(res));
        expect_val({nm, "_fix_pc"}, fix);
        #1;
        check_val(word_t'(bp.up_result));
        check_val(bp.up_fix_pc);
    endtask

    task automatic stat(input string nm, input word_t lk, input word_t mp);
        expect_val({nm, "_n_lookups"}, lk);
        expect_val({nm, "_n_mispred"}, mp);
        check_val(bp.n_lookups);
        check_val(bp.n_mispred);
    endtask

    task automatic cnt(input string nm, input word_t c);
        expect_val({nm, "_counter"}, c);
        check_val(word_t'(dut.cnt_q[0]));
    endtask

    initial begin
        rst         = 1'b1;
        bp.lk_pc    = '0;
        bp.lk_stall = 1'b1;
        drive_up(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Held in reset: empty table, zeroed statistics.
        @(negedge clk);
        look("rst", 32'h40, 1'b0, 1'b0, 32'h44);
        upchk("rst_na", NA, 32'h4);
        stat("rst", 0, 0);
        cnt("rst", 0);

        // Release reset with an allocating update in the same cycle.
        @(negedge clk);
        rst         = 1'b0;
        bp.lk_stall = 1'b0;
        drive_up(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        look("first", 32'h40, 1'b0, 1'b0, 32'h44);
        upchk("alloc", WRONG_PRED, 32'h100);

        @(negedge clk);
        bp.lk_stall = 1'b1;
        drive_up(1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
        upchk("idle_na", NA, 32'h100);
        cnt("alloc", 2);
        stat("alloc", 1, 1);

        // Not-taken updates count down and saturate at zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_up(1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
            upchk("nt", WRONG_PRED, 32'h44);
            @(negedge clk);
            drive_up(1'b0, 32'h40, 1'b0, 32'h100, 1'b0, 32'h0);
            cnt($sformatf("nt%0d", i), nt_exp[i]);
        end
        look("sat0", 32'h40, 1'b1, 1'b0, 32'h44);
        stat("sat0", 1, 4);

        // Taken updates count up and saturate at three.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_up(1'b1, 32'h40, 1'b1, 32'h100, (i >= 2), 32'h100);
            upchk("tk", (i >= 2) ? RIGHT_PRED : WRONG_PRED, 32'h100);
            @(negedge clk);
            drive_up(1'b0, 32'h40, 1'b0, 32'h100, 1'b0, 32'h0);
            cnt($sformatf("tk%0d", i), tk_exp[i]);
        end
        stat("sat3", 1, 6);

        // Correct direction but wrong target is a mispredict; no edge is crossed here.
        drive_up(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h104);
        upchk("badtgt", WRONG_PRED, 32'h100);
        drive_up(1'b0, 32'h40, 1'b0, 32'h100, 1'b0, 32'h0);

        // Alias: 0x80 shares index 0 with 0x40 but has a different tag.
        @(negedge clk);
        drive_up(1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
        upchk("alias", WRONG_PRED, 32'h200);
        @(negedge clk);
        drive_up(1'b0, 32'h80, 1'b0, 32'h200, 1'b0, 32'h0);
        look("alias_old", 32'h40, 1'b0, 1'b0, 32'h44);
        look("alias_new", 32'h80, 1'b1, 1'b1, 32'h200);
        look("lowbits", 32'h83, 1'b1, 1'b1, 32'h200);
        cnt("alias", 2);
        stat("alias", 1, 7);

        // Same-cycle lookup and update: old contents now, new contents next cycle.
        @(negedge clk);
        drive_up(1'b1, 32'h80, 1'b1, 32'h300, 1'b1, 32'h200);
        look("same_pre", 32'h80, 1'b1, 1'b1, 32'h200);
        upchk("same", WRONG_PRED, 32'h300);
        @(negedge clk);
        drive_up(1'b0, 32'h80, 1'b0, 32'h300, 1'b0, 32'h0);
        look("same_post", 32'h80, 1'b1, 1'b1, 32'h300);
        cnt("same", 3);
        stat("same", 1, 8);

        // Not-taken miss leaves the table untouched.
        @(negedge clk);
        drive_up(1'b1, 32'hC0, 1'b0, 32'h999, 1'b0, 32'h0);
        upchk("ntmiss", RIGHT_PRED, 32'hC4);
        @(negedge clk);
        drive_up(1'b0, 32'hC0, 1'b0, 32'h999, 1'b0, 32'h0);
        look("ntmiss_c0", 32'hC0, 1'b0, 1'b0, 32'hC4);
        look("ntmiss_80", 32'h80, 1'b1, 1'b1, 32'h300);
        cnt("ntmiss", 3);
        stat("ntmiss", 1, 8);

        // Three unstalled cycles.
        @(negedge clk);
        bp.lk_stall = 1'b0;
        repeat (3) @(negedge clk);
        bp.lk_stall = 1'b1;
        stat("lookups", 4, 8);

        // Asynchronous reset between edges clears everything at once.
        bp.lk_pc = 32'h80;
        #2;
        rst = 1'b1;
        #1;
        look("async", 32'h80, 1'b0, 1'b0, 32'h84);
        stat("async", 0, 0);
        cnt("async", 0);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        look("post_rst_80", 32'h80, 1'b0, 1'b0, 32'h84);
        look("post_rst_40", 32'h40, 1'b0, 1'b0, 32'h44);
        stat("post_rst", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
